fetch_pipe_ctrl: RTL

FETCH_PIPE_CTRL -- requirements
Module: fetch_pipe_ctrl

---
 rtl/fetch_pipe_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/fetch_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pipe_ctrl
// Brief   : Instruction-fetch PC sequencer and IF/ID pipeline register with
//           branch/jump redirect, stall/flush handling, a sticky misaligned
//           redirect flag and saturating stall/flush performance counters.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_pipe_ctrl #(
   parameter int          DWIDTH   = 32,
   parameter int          AWIDTH   = 32,
   parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
   parameter int          CNTW     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_if,
   input  logic              ifid_wren,
   input  logic              ifid_flush,
   input  logic              e_redirect,
   input  logic [AWIDTH-1:0] e_target,
   input  logic [DWIDTH-1:0] f_insn,
   output logic [AWIDTH-1:0] f_pc,
   output logic [AWIDTH-1:0] d_pc,
   output logic [DWIDTH-1:0] d_insn,
   output logic              d_valid,
   output logic              misalign_err,
   output logic [CNTW-1:0]   stall_cnt,
   output logic [CNTW-1:0]   flush_cnt
);

   // addi x0,x0,0 - the canonical NOP placed in IF/ID on a flush
   localparam logic [DWIDTH-1:0] NOP      = DWIDTH'(32'h0000_0013);
   localparam logic [CNTW-1:0]   CNT_MAX  = '1;
   localparam logic [AWIDTH-1:0] PC_INCR  = AWIDTH'(4);

   // Aligned redirect target: low two bits are forced to zero so the PC
   // always stays word-aligned even when EX produces a bad target.
   logic [AWIDTH-1:0] redirect_pc;
   assign redirect_pc = {e_target[AWIDTH-1:2], 2'b00};

   // Fetch PC: redirect beats stall so a flush is never lost; increment wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         f_pc <= BASEADDR;
      end else if (e_redirect) begin
         f_pc <= redirect_pc;
      end else if (!stall_if) begin
         f_pc <= f_pc + PC_INCR;
      end
   end

   // IF/ID register: flush inserts a NOP even while the register is held.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_pc    <= BASEADDR;
         d_insn  <= NOP;
         d_valid <= 1'b0;
      end else if (ifid_flush) begin
         d_pc    <= f_pc;
         d_insn  <= NOP;
         d_valid <= 1'b0;
      end else if (ifid_wren) begin
         d_pc    <= f_pc;
         d_insn  <= f_insn;
         d_valid <= 1'b1;
      end
   end

   // Sticky misaligned-redirect flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_err <= 1'b0;
      end else if (e_redirect && (e_target[1:0] != 2'b00)) begin
         misalign_err <= 1'b1;
      end
   end

   // Stall counter: counts cycles the PC really held (redirect overrides).
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (stall_if && !e_redirect && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNTW'(1);
      end
   end

   // Flush counter: counts IF/ID flush cycles, saturating.
   always_ff @(posedge clk) begin
      if (reset) begin
         flush_cnt <= '0;
      end else if (ifid_flush && (flush_cnt != CNT_MAX)) begin
         flush_cnt <= flush_cnt + CNTW'(1);
      end
   end

endmodule
`default_nettype wire
